// File: rtl/avalon_mm_csr_bank.sv
// rtl/avalon_mm_csr_bank.sv - parametrised Avalon-MM control/status register bank
module avalon_mm_csr_bank #(
  parameter int                  ADDR_W       = 4,
  parameter int                  DATA_W       = 32,
  parameter int                  REG_NUM      = 16,
  parameter int                  READ_LATENCY = 1,
  parameter logic [REG_NUM-1:0]  RO_MASK      = '0,
  parameter logic [DATA_W-1:0]   RESET_VAL    = '0
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [ADDR_W-1:0]         address_i,
  input  logic                      write_i,
  input  logic [DATA_W-1:0]         writedata_i,
  input  logic [DATA_W/8-1:0]       byteenable_i,
  input  logic                      read_i,
  output logic                      waitrequest_o,
  output logic [DATA_W-1:0]         readdata_o,
  output logic                      readdatavalid_o,
  input  logic [REG_NUM*DATA_W-1:0] ro_data_i,
  output logic [REG_NUM*DATA_W-1:0] regs_o,
  output logic [REG_NUM-1:0]        reg_wr_o
);

  localparam int BE_W = DATA_W / 8;

  // High for the single cycle that follows reset release.
  logic rst_hold;
  logic busy_rst;
  logic wr_acc;
  logic rd_acc;

  // Storage for RW registers; entries behind RO_MASK bits are never written.
  logic [DATA_W-1:0] reg_q   [REG_NUM];
  // Value a read of register i would return (RO status or RW storage).
  logic [DATA_W-1:0] reg_val [REG_NUM];
  logic [REG_NUM-1:0] wr_hit;
  logic [DATA_W-1:0]  rd_data;

  // Read response shift pipeline; stage 0 captures at the acceptance edge.
  logic              vld_p [READ_LATENCY];
  logic [DATA_W-1:0] dat_p [READ_LATENCY];

  assign busy_rst      = srst_i | rst_hold;
  // A simultaneous read and write lets the write through and stalls the read.
  assign waitrequest_o = busy_rst | (read_i & write_i);
  assign wr_acc        = write_i & ~busy_rst;
  assign rd_acc        = read_i & ~waitrequest_o;

  // Track the one-cycle stall window after reset release.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rst_hold <= 1'b1;
    end else begin
      rst_hold <= 1'b0;
    end
  end

  // Per-register read value, exported contents and write-hit decode.
  always_comb begin
    regs_o  = '0;
    wr_hit  = '0;
    rd_data = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      reg_val[i] = RO_MASK[i] ? ro_data_i[i*DATA_W +: DATA_W] : reg_q[i];
      if (!RO_MASK[i]) begin
        regs_o[i*DATA_W +: DATA_W] = reg_q[i];
      end
      if (address_i == ADDR_W'(i)) begin
        rd_data = reg_val[i];
        wr_hit[i] = wr_acc & ~RO_MASK[i];
      end
    end
  end

  // Byte-lane writes into RW registers.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int i = 0; i < REG_NUM; i++) begin
        reg_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (wr_hit[i]) begin
          for (int k = 0; k < BE_W; k++) begin
            if (byteenable_i[k]) begin
              reg_q[i][k*8 +: 8] <= writedata_i[k*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Write strobe pulses in the cycle after the accepted write.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      reg_wr_o <= '0;
    end else begin
      reg_wr_o <= wr_hit;
    end
  end

  // Read pipeline: data sampled before any same-edge write, zero when idle.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        vld_p[s] <= 1'b0;
        dat_p[s] <= '0;
      end
    end else begin
      vld_p[0] <= rd_acc;
      dat_p[0] <= rd_acc ? rd_data : '0;
      for (int s = 1; s < READ_LATENCY; s++) begin
        vld_p[s] <= vld_p[s-1];
        dat_p[s] <= dat_p[s-1];
      end
    end
  end

  // Registered response outputs, landing READ_LATENCY edges after acceptance.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      readdatavalid_o <= 1'b0;
      readdata_o      <= '0;
    end else begin
      readdatavalid_o <= vld_p[READ_LATENCY-1];
      readdata_o      <= dat_p[READ_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_avalon_mm_csr_bank.sv
// tb/tb_avalon_mm_csr_bank.sv - self-checking bench for avalon_mm_csr_bank
module tb_avalon_mm_csr_bank;

  localparam int               ADDR_W = 4;
  localparam int               DATA_W = 32;
  localparam int               REG_NUM = 8;
  localparam int               LAT = 3;
  localparam logic [REG_NUM-1:0] RO_MASK = 8'hA0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      srst;
  logic [ADDR_W-1:0]         address;
  logic                      write;
  logic [DATA_W-1:0]         writedata;
  logic [DATA_W/8-1:0]       byteenable;
  logic                      read;
  logic                      waitrequest_o;
  logic [DATA_W-1:0]         readdata_o;
  logic                      readdatavalid_o;
  logic [REG_NUM*DATA_W-1:0] ro_data;
  logic [REG_NUM*DATA_W-1:0] regs_o;
  logic [REG_NUM-1:0]        reg_wr_o;

  avalon_mm_csr_bank #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_NUM(REG_NUM),
    .READ_LATENCY(LAT), .RO_MASK(RO_MASK), .RESET_VAL(32'h0)
  ) dut (
    .clk_i(clk), .srst_i(srst), .address_i(address), .write_i(write),
    .writedata_i(writedata), .byteenable_i(byteenable), .read_i(read),
    .waitrequest_o(waitrequest_o), .readdata_o(readdata_o),
    .readdatavalid_o(readdatavalid_o), .ro_data_i(ro_data),
    .regs_o(regs_o), .reg_wr_o(reg_wr_o)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t        resp_q[$];
  logic [31:0]  mreg [REG_NUM];
  logic         rst_hold_m = 1'b0;
  logic [REG_NUM-1:0] exp_reg_wr;
  int           edge_cnt = 0;
  int           nchecks = 0;
  int           npass = 0;
  bit           mon_en = 1'b0;

  always @(posedge clk) edge_cnt++;

  // Response scoreboard: every cycle the output must match the scheduled reply or be idle zero.
  always @(negedge clk) begin
    logic        ev;
    logic [31:0] ed;
    if (mon_en) begin
      ev = 1'b0;
      ed = '0;
      if (resp_q.size() > 0 && resp_q[0].due == edge_cnt) begin
        ev = 1'b1;
        ed = resp_q[0].data;
        void'(resp_q.pop_front());
      end
      nchecks++;
      if (readdatavalid_o !== ev || readdata_o !== ed)
        $display("FAIL rd_resp edge %0d: got valid=%0b data=%h, want valid=%0b data=%h",
                 edge_cnt, readdatavalid_o, readdata_o, ev, ed);
      else
        npass++;
    end
  end

  function automatic logic [REG_NUM*DATA_W-1:0] exp_regs();
    logic [REG_NUM*DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < REG_NUM; i++)
      if (!RO_MASK[i]) v[i*DATA_W +: DATA_W] = mreg[i];
    return v;
  endfunction

  task automatic set_in(input logic rst, input logic w, input logic r, input logic [3:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    srst = rst; write = w; read = r; address = a; writedata = wd; byteenable = be;
  endtask

  // Advance one clock, applying the bank's rules to the model for the upcoming edge.
  task automatic tick();
    int          a;
    logic        ok;
    logic [31:0] d;
    resp_t       rsp;
    a = int'(address);
    ok = !srst && !rst_hold_m;
    exp_reg_wr = '0;
    if (srst) begin
      for (int i = 0; i < REG_NUM; i++) mreg[i] = 32'h0;
      while (resp_q.size() > 0 && resp_q[$].due >= edge_cnt + 1) void'(resp_q.pop_back());
    end else begin
      if (ok && read && !write) begin
        d = 32'h0;
        if (a < REG_NUM) d = RO_MASK[a] ? ro_data[a*32 +: 32] : mreg[a];
        rsp.due = edge_cnt + 1 + LAT;
        rsp.data = d;
        resp_q.push_back(rsp);
      end
      if (ok && write && a < REG_NUM && !RO_MASK[a]) begin
        for (int k = 0; k < 4; k++)
          if (byteenable[k]) mreg[a][k*8 +: 8] = writedata[k*8 +: 8];
        exp_reg_wr[a] = 1'b1;
      end
    end
    rst_hold_m = srst;
    @(posedge clk);
    #3;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    set_in(1, 0, 0, 0, 0, 0);
    tick();
    mon_en = 1'b1;
    tick();
    #1;
    nchecks++;
    if (waitrequest_o !== 1'b1) $display("FAIL wait_in_reset: got %b want 1", waitrequest_o); else npass++;
    set_in(0, 0, 1, 0, 0, 0);
    #1;
    nchecks++;
    if (waitrequest_o !== 1'b1) $display("FAIL wait_after_release: got %b want 1", waitrequest_o); else npass++;
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    nchecks++;
    if (waitrequest_o !== 1'b0) $display("FAIL wait_released: got %b want 0", waitrequest_o); else npass++;
    nchecks++;
    if (regs_o !== '0) $display("FAIL regs_reset: got %h want 0", regs_o); else npass++;
    nchecks++;
    if (reg_wr_o !== '0) $display("FAIL reg_wr_reset: got %b want 0", reg_wr_o); else npass++;
  endtask

  task automatic test_byteenable();
    set_in(0, 1, 0, 2, 32'hAABBCCDD, 4'b0101);
    #1;
    nchecks++;
    if (waitrequest_o !== 1'b0) $display("FAIL be_wait: got %b want 0", waitrequest_o); else npass++;
    tick();
    nchecks++;
    if (reg_wr_o !== 8'b0000_0100) $display("FAIL be_strobe: got %b want 00000100", reg_wr_o); else npass++;
    nchecks++;
    if (regs_o[95:64] !== 32'h00BB00DD) $display("FAIL be_reg2: got %h want 00bb00dd", regs_o[95:64]); else npass++;
    idle(1);
    nchecks++;
    if (reg_wr_o !== '0) $display("FAIL be_strobe_once: got %b want 0", reg_wr_o); else npass++;
    set_in(0, 0, 1, 2, 0, 0);
    tick();
    idle(LAT);
    nchecks++;
    if (readdatavalid_o !== 1'b1 || readdata_o !== 32'h00BB00DD)
      $display("FAIL be_read: got valid=%b data=%h want valid=1 data=00bb00dd", readdatavalid_o, readdata_o);
    else npass++;
  endtask

  task automatic test_pipelined();
    logic [31:0] got[$];
    int first_j;
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 0, 4'(i), 32'h10 + i, 4'hF);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 1, 4'(i), 0, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0);
    first_j = -1;
    for (int j = 0; j < 8; j++) begin
      if (readdatavalid_o === 1'b1) begin
        if (first_j < 0) first_j = j;
        got.push_back(readdata_o);
      end
      tick();
    end
    nchecks++;
    if (first_j !== 0) $display("FAIL pipe_first_cycle: got offset %0d want 0", first_j); else npass++;
    nchecks++;
    if (got.size() !== 4) $display("FAIL pipe_count: got %0d want 4", got.size()); else npass++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      nchecks++;
      if (got[i] !== 32'h10 + i) $display("FAIL pipe_data[%0d]: got %h want %h", i, got[i], 32'h10 + i);
      else npass++;
    end
  endtask

  task automatic test_ro_oor();
    set_in(0, 1, 0, 5, 32'hFFFFFFFF, 4'hF);
    tick();
    nchecks++;
    if (reg_wr_o !== '0) $display("FAIL ro_strobe: got %b want 0", reg_wr_o); else npass++;
    set_in(0, 1, 0, 15, 32'hFFFFFFFF, 4'hF);
    #1;
    nchecks++;
    if (waitrequest_o !== 1'b0) $display("FAIL oor_wait: got %b want 0", waitrequest_o); else npass++;
    tick();
    nchecks++;
    if (reg_wr_o !== '0) $display("FAIL oor_strobe: got %b want 0", reg_wr_o); else npass++;
    nchecks++;
    if (regs_o !== exp_regs()) $display("FAIL ro_regs: got %h want %h", regs_o, exp_regs()); else npass++;
    set_in(0, 0, 1, 5, 0, 0);
    tick();
    set_in(0, 0, 1, 15, 0, 0);
    tick();
    idle(LAT - 1);
    nchecks++;
    if (readdatavalid_o !== 1'b1 || readdata_o !== 32'h12345678)
      $display("FAIL ro_read: got valid=%b data=%h want valid=1 data=12345678", readdatavalid_o, readdata_o);
    else npass++;
    idle(1);
    nchecks++;
    if (readdatavalid_o !== 1'b1 || readdata_o !== 32'h0)
      $display("FAIL oor_read: got valid=%b data=%h want valid=1 data=0", readdatavalid_o, readdata_o);
    else npass++;
  endtask

  task automatic test_collision();
    set_in(0, 1, 0, 1, 32'h1, 4'hF);
    tick();
    set_in(0, 1, 1, 1, 32'h2, 4'hF);
    #1;
    nchecks++;
    if (waitrequest_o !== 1'b1) $display("FAIL coll_wait: got %b want 1", waitrequest_o); else npass++;
    tick();
    nchecks++;
    if (regs_o[63:32] !== 32'h2 || reg_wr_o !== 8'b0000_0010)
      $display("FAIL coll_write: got reg1=%h strobe=%b want reg1=2 strobe=00000010", regs_o[63:32], reg_wr_o);
    else npass++;
    set_in(0, 0, 1, 1, 0, 0);
    #1;
    nchecks++;
    if (waitrequest_o !== 1'b0) $display("FAIL coll_read_wait: got %b want 0", waitrequest_o); else npass++;
    tick();
    idle(LAT);
    nchecks++;
    if (readdatavalid_o !== 1'b1 || readdata_o !== 32'h2)
      $display("FAIL coll_read: got valid=%b data=%h want valid=1 data=2", readdatavalid_o, readdata_o);
    else npass++;
  endtask

  task automatic test_reset_mid_read();
    int seen;
    set_in(0, 0, 1, 2, 0, 0);
    tick();
    idle(1);
    set_in(1, 0, 0, 0, 0, 0);
    tick();
    seen = 0;
    set_in(0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 6; j++) begin
      tick();
      if (readdatavalid_o === 1'b1) seen++;
    end
    nchecks++;
    if (seen != 0) $display("FAIL rst_flush: got %0d responses want 0", seen); else npass++;
    nchecks++;
    if (regs_o !== '0) $display("FAIL rst_regs: got %h want 0", regs_o); else npass++;
    set_in(0, 0, 1, 2, 0, 0);
    tick();
    idle(LAT);
    nchecks++;
    if (readdatavalid_o !== 1'b1 || readdata_o !== 32'h0)
      $display("FAIL rst_readback: got valid=%b data=%h want valid=1 data=0", readdatavalid_o, readdata_o);
    else npass++;
  endtask

  task automatic test_random();
    logic r, w, rst, exp_wait;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) ro_data[$urandom_range(0, REG_NUM-1)*32 +: 32] = $urandom;
      rst = ($urandom_range(0, 63) == 0);
      w = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 1) == 1;
      set_in(rst, w, r, 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      #1;
      exp_wait = rst || rst_hold_m || (r && w);
      nchecks++;
      if (waitrequest_o !== exp_wait) $display("FAIL rnd_wait[%0d]: got %b want %b", n, waitrequest_o, exp_wait);
      else npass++;
      tick();
      nchecks++;
      if (regs_o !== exp_regs()) $display("FAIL rnd_regs[%0d]: got %h want %h", n, regs_o, exp_regs());
      else npass++;
      nchecks++;
      if (reg_wr_o !== exp_reg_wr) $display("FAIL rnd_strobe[%0d]: got %b want %b", n, reg_wr_o, exp_reg_wr);
      else npass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ro_data = '0;
    ro_data[5*32 +: 32] = 32'h12345678;
    ro_data[7*32 +: 32] = 32'hCAFEF00D;
    for (int i = 0; i < REG_NUM; i++) mreg[i] = 32'h0;
    exp_reg_wr = '0;
    set_in(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    test_reset();
    test_byteenable();
    test_pipelined();
    test_ro_oor();
    test_collision();
    test_reset_mid_read();
    test_random();
    idle(LAT + 2);
    nchecks++;
    if (resp_q.size() != 0) $display("FAIL drain: got %0d pending responses want 0", resp_q.size());
    else npass++;
    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule
